// File: rtl/ring_pkg.sv
// Ring word layout shared by the ring endpoints (default 16-bit word, 3-bit addresses).
package ring_pkg;
    localparam int RING_WIDTH = 16;
    localparam int RING_ABITS = 3;
    localparam int FULL_BIT   = RING_WIDTH - 1;
    localparam int DEST_LSB   = FULL_BIT - RING_ABITS;
    localparam int SRC_LSB    = DEST_LSB - RING_ABITS;
    localparam int DBITS      = SRC_LSB;

    typedef struct packed {
        logic                  full;
        logic [RING_ABITS-1:0] dest;
        logic [RING_ABITS-1:0] src;
        logic [DBITS-1:0]      payload;
    } ring_word_t;

    localparam logic [RING_WIDTH-1:0] EMPTY_SLOT = '0;

    function automatic int dbits_of(input int width, input int abits);
        return width - 1 - 2 * abits;
    endfunction
endpackage

// File: rtl/ring_fifo.sv
// Show-ahead FIFO; push is ignored when full and pop when empty.
module ring_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/ring_fifo_node.sv
// Buffered parallel-client ring endpoint: consume to RX FIFO, insert from TX FIFO, forward rest.
// Optional RING_ORPHAN_DROP_EN drops own words that circled the ring undelivered.
module ring_fifo_node
    import ring_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ABITS   = 3,
    parameter int ADDRESS = 1,
    parameter int DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [WIDTH-1:0]                   fromring,
    output logic [WIDTH-1:0]                   toring,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    input  logic [ABITS-1:0]                   tx_dest,
    input  logic [dbits_of(WIDTH, ABITS)-1:0]  tx_data,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic [ABITS-1:0]                   rx_src,
    output logic [dbits_of(WIDTH, ABITS)-1:0]  rx_data,
    output logic                               orphan
);
    localparam int DB = dbits_of(WIDTH, ABITS);
    localparam int FB = WIDTH - 1;
    localparam int DL = FB - ABITS;
    localparam int SL = DL - ABITS;
    localparam logic [ABITS-1:0] ME = ABITS'(ADDRESS);

    logic             w_full;
    logic [ABITS-1:0] w_dest;
    logic [ABITS-1:0] w_src;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic             consume, drop, slot_free, insert;
    logic [ABITS+DB-1:0] tx_head, rx_head;
    logic [WIDTH-1:0] next_word;

    assign w_full = fromring[FB];
    assign w_dest = fromring[DL +: ABITS];
    assign w_src  = fromring[SL +: ABITS];

    // rx_full reflects this cycle's count, so a same-cycle pop cannot make room.
    assign consume = w_full && (w_dest == ME) && !rx_full;
`ifdef RING_ORPHAN_DROP_EN
    assign drop = w_full && (w_src == ME) && (w_dest != ME);
`else
    assign drop = 1'b0;
`endif
    assign slot_free = !w_full || consume || drop;
    assign insert    = slot_free && !tx_empty;

    always_comb begin
        next_word = fromring;
        if (consume || drop) next_word = WIDTH'(EMPTY_SLOT);
        if (insert)          next_word = {1'b1, tx_head[DB +: ABITS], ME, tx_head[DB-1:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) toring <= '0;
        else      toring <= next_word;
    end

`ifdef RING_ORPHAN_DROP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      orphan <= 1'b0;
        else if (drop) orphan <= 1'b1;
    end
`else
    assign orphan = 1'b0;
`endif

    ring_fifo #(.WIDTH(ABITS + DB), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .wdata ({tx_dest, tx_data}),
        .pop   (insert),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    ring_fifo #(.WIDTH(ABITS + DB), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (consume),
        .wdata ({w_src, fromring[DB-1:0]}),
        .pop   (rx_ready),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign rx_src   = rx_head[DB +: ABITS];
    assign rx_data  = rx_head[DB-1:0];
endmodule

// File: tb/tb_ring_fifo_node.sv
// Self-checking bench for ring_fifo_node (ADDRESS=2) against a queue-based slot model.
module tb_ring_fifo_node;
    import ring_pkg::*;

    localparam int A = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] fromring = 16'h0000;
    logic [15:0] toring;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [2:0]  tx_dest = 3'd0;
    logic [8:0]  tx_data = 9'd0;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [2:0]  rx_src;
    logic [8:0]  rx_data;
    logic        orphan;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] tx_q[$];
    logic [11:0] rx_q[$];
    bit          orphan_m = 1'b0;

    ring_fifo_node #(.WIDTH(16), .ABITS(3), .ADDRESS(A), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .fromring (fromring),
        .toring   (toring),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_dest  (tx_dest),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_src   (rx_src),
        .rx_data  (rx_data),
        .orphan   (orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One ring cycle: predict from the slot rules, advance the clock, compare.
    task automatic cycle();
        ring_word_t  w;
        logic [15:0] exp_out;
        logic [11:0] head;
        bit cons, orph, ins, rxpop, txpush;
        w    = fromring;
        cons = w.full && (w.dest == 3'(A)) && (rx_q.size() < D);
        orph = 1'b0;
`ifdef RING_ORPHAN_DROP_EN
        orph = w.full && (w.src == 3'(A)) && (w.dest != 3'(A));
`endif
        exp_out = (cons || orph) ? 16'h0000 : fromring;
        ins = (!w.full || cons || orph) && (tx_q.size() > 0);
        if (ins) begin
            head    = tx_q[0];
            exp_out = {1'b1, head[11:9], 3'(A), head[8:0]};
        end
        rxpop  = rx_ready && (rx_q.size() > 0);
        txpush = tx_valid && (tx_q.size() < D);
        @(posedge clk);
        #1;
        if (rxpop)  void'(rx_q.pop_front());
        if (cons)   rx_q.push_back({w.src, w.payload});
        if (ins)    void'(tx_q.pop_front());
        if (txpush) tx_q.push_back({tx_dest, tx_data});
        if (orph)   orphan_m = 1'b1;
        chk("model_toring", toring, exp_out);
        chk("model_tx_ready", tx_ready, tx_q.size() < D);
        chk("model_rx_valid", rx_valid, rx_q.size() > 0);
        if (rx_q.size() > 0) begin
            head = rx_q[0];
            chk("model_rx_src", rx_src, head[11:9]);
            chk("model_rx_data", rx_data, head[8:0]);
        end
        chk("model_orphan", orphan, orphan_m);
    endtask

    typedef struct {
        logic [15:0] fr;
        logic        txv;
        logic [2:0]  dest;
        logic [8:0]  data;
        logic        rxr;
        logic [15:0] exp_out;
        logic        exp_rxv;
    } vec_t;

    vec_t        vecs[9];
    logic [15:0] rxf_exp[7];
    logic        rxf_rdy[7];
    logic [15:0] orph_exp;
    logic        orph_flag_exp;
    ring_word_t  rw;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h3123, 1'b0, 3'd0, 9'h000, 1'b0, 16'h3123, 1'b0};
        vecs[1] = '{16'hAAAB, 1'b0, 3'd0, 9'h000, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h0000, 1'b1, 3'd3, 9'h055, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{16'h0000, 1'b0, 3'd0, 9'h000, 1'b0, 16'hB455, 1'b1};
        vecs[4] = '{16'hAAAB, 1'b1, 3'd3, 9'h055, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'hAAAB, 1'b0, 3'd0, 9'h000, 1'b0, 16'hB455, 1'b1};
        vecs[6] = '{16'h0000, 1'b0, 3'd0, 9'h000, 1'b1, 16'h0000, 1'b1};
        vecs[7] = '{16'h0000, 1'b0, 3'd0, 9'h000, 1'b1, 16'h0000, 1'b1};
        vecs[8] = '{16'h0000, 1'b0, 3'd0, 9'h000, 1'b1, 16'h0000, 1'b0};
        rxf_exp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hAAAB, 16'hAAAB, 16'h0000};
        rxf_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state, with traffic on the ring
        fromring = 16'h3123;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_toring", toring, 16'h0000);
        chk("reset_tx_ready", tx_ready, 1'b1);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_orphan", orphan, 1'b0);
        rst = 1'b1;

        // Directed table: pass-through, receive, insert, consume+insert, pops
        for (int i = 0; i < 9; i++) begin
            fromring = vecs[i].fr;
            tx_valid = vecs[i].txv;
            tx_dest  = vecs[i].dest;
            tx_data  = vecs[i].data;
            rx_ready = vecs[i].rxr;
            cycle();
            chk($sformatf("vec%0d_toring", i), toring, vecs[i].exp_out);
            chk($sformatf("vec%0d_rx_valid", i), rx_valid, vecs[i].exp_rxv);
            if (i == 1) begin
                chk("vec1_rx_src", rx_src, 3'd5);
                chk("vec1_rx_data", rx_data, 9'h0AB);
            end
            if (i == 3) chk("vec3_tx_ready", tx_ready, 1'b1);
        end
        tx_valid = 1'b0;

        // RX full: fifth word recirculates; a same-cycle pop does not make room
        for (int i = 0; i < 7; i++) begin
            fromring = 16'hAAAB;
            rx_ready = rxf_rdy[i];
            cycle();
            chk($sformatf("rxfull%0d_toring", i), toring, rxf_exp[i]);
        end
        fromring = 16'h0000;
        rx_ready = 1'b1;
        repeat (4) cycle();
        chk("rxfull_drained", rx_valid, 1'b0);
        rx_ready = 1'b0;

        // TX full: occupied slots block insertion, fifth push refused, order kept
        fromring = 16'hC000;
        tx_valid = 1'b1;
        tx_dest  = 3'd3;
        for (int i = 0; i < 5; i++) begin
            tx_data = 9'(i);
            cycle();
            chk($sformatf("txfull%0d_fwd", i), toring, 16'hC000);
        end
        chk("txfull_ready", tx_ready, 1'b0);
        tx_valid = 1'b0;
        fromring = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("txdrain%0d", i), toring, (i < 4) ? (16'hB400 | 16'(i)) : 16'h0000);
        end

        // Orphan: own word addressed elsewhere coming back around
`ifdef RING_ORPHAN_DROP_EN
        orph_exp      = 16'h0000;
        orph_flag_exp = 1'b1;
`else
        orph_exp      = 16'hB455;
        orph_flag_exp = 1'b0;
`endif
        fromring = 16'hB455;
        cycle();
        chk("orphan_toring", toring, orph_exp);
        chk("orphan_flag", orphan, orph_flag_exp);
        fromring = 16'h3123;
        cycle();
        chk("orphan_sticky", orphan, orph_flag_exp);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rw.full    = ($urandom_range(0, 3) != 0);
            rw.dest    = ($urandom_range(0, 2) == 0) ? 3'(A) : 3'($urandom_range(0, 7));
            rw.src     = 3'($urandom_range(0, 7));
            rw.payload = 9'($urandom);
            fromring   = rw;
            tx_valid   = $urandom_range(0, 1) == 1;
            tx_dest    = 3'($urandom_range(0, 7));
            tx_data    = 9'($urandom);
            rx_ready   = $urandom_range(0, 2) == 0;
            cycle();
        end

        // Asynchronous reset mid-traffic, away from the clock edge
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_toring", toring, 16'h0000);
        chk("async_reset_tx_ready", tx_ready, 1'b1);
        chk("async_reset_rx_valid", rx_valid, 1'b0);
        chk("async_reset_orphan", orphan, 1'b0);
        tx_q.delete();
        rx_q.delete();
        orphan_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        fromring = 16'h3123;
        cycle();
        chk("post_reset_pass", toring, 16'h3123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ring_fifo_node.md
Name: ring_fifo_node

Overview:
- Buffered ring endpoint for a parallel (non-SPI) client on the same slotted 16-bit ring as the SPI node; sits directly up/downstream of it in the ring chain.
- Removes words addressed to ADDRESS into an RX FIFO.
- Inserts client words from a TX FIFO into empty slots.
- Forwards everything else with one register of latency.

Parameters:
- WIDTH, 16, ring word width.
- ABITS, 3, node address width.
- ADDRESS, 1, this node's ring address.
- DEPTH, 4, entries per FIFO; power of two, at least 2.

Ports:
- clk  in  1  ring clock
- rst  in  1  asynchronous, active-low reset
- fromring  in  WIDTH  word from upstream node
- toring  out  WIDTH  registered word to downstream node
- tx_valid  in  1  client offers a word
- tx_ready  out  1  TX FIFO not full
- tx_dest  in  ABITS  destination address
- tx_data  in  DBITS  payload; DBITS = WIDTH-1-2*ABITS (9 by default)
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  client accepts head word
- rx_src  out  ABITS  source of the head word
- rx_data  out  DBITS  payload of the head word
- orphan  out  1  sticky orphan-drop flag

Behaviour:
- Ring word layout:
  - [WIDTH-1] full
  - [WIDTH-2 -: ABITS] dest
  - next ABITS src
  - low DBITS payload
  - full=0 marks an empty slot; the other fields are don't-care.
- Reset (rst=0, asynchronous):
  - toring=0; both FIFOs emptied; orphan=0.
  - tx_ready=1, rx_valid=0.
  - Words in flight are lost.
- Per-cycle slot processing (w=fromring), result registered into toring; latency exactly 1 cycle:
  - Consume: if w.full, w.dest==ADDRESS and the RX FIFO is not full, push {src,payload} and mark the slot empty.
  - RX full: the word passes unchanged and retries next lap. The full test uses this cycle's count, so a simultaneous rx pop does not free space.
  - Insert: if the slot is empty after consume and the TX FIFO is non-empty, toring={1,tx_head.dest,ADDRESS,tx_head.payload} and pop TX.
  - Consume and insert may both happen in one cycle.
  - Otherwise toring=w unchanged.
- A word addressed to ADDRESS with src==ADDRESS (self-send) is consumed like any other word.
- Client handshakes:
  - TX push when tx_valid && tx_ready.
  - RX pop when rx_valid && rx_ready.
  - rx_src/rx_data are show-ahead, valid while rx_valid=1, and stable until popped.
- TX write-to-insert: a word pushed in cycle n is eligible for insertion in cycle n+1 at the earliest.
- FIFO push and pop in the same cycle:
  - allowed when the FIFO is neither full nor empty;
  - count unchanged; pointers wrap modulo DEPTH.
- Ordering: FIFO order is preserved per direction. No ordering is guaranteed between words recirculated because of RX-full.

Optional Feature:
- Macro: RING_ORPHAN_DROP_EN.
- Defined: an incoming full word with src==ADDRESS and dest!=ADDRESS has circled the ring undelivered.
  - It is dropped (slot becomes empty and is usable for insert the same cycle).
  - orphan is set and stays 1 until reset.
- Undefined: such words are forwarded unchanged; orphan is tied to 0.

Decomposition:
- Shared package ring_pkg:
  - field-position localparams (FULL_BIT, DEST_LSB, SRC_LSB, DBITS);
  - a ring word struct typedef;
  - the empty-slot constant.
- One sub-module, ring_fifo (parameters WIDTH, DEPTH; show-ahead; full/empty outputs), instantiated twice: TX and RX.

Test Plan:
- Reset and pass-through, ADDRESS=2: release reset, drive fromring=0x3123 (dest=3) → toring=0x3123 one cycle later; toring=0x0000 during reset.
- Receive, ADDRESS=2: fromring=0xAAAB (dest 2, src 5, payload 0x0AB) → toring=0x0000 next cycle; rx_valid=1, rx_src=5, rx_data=0x0AB.
- Insert: tx_dest=3, tx_data=0x055, push once, then an empty slot arrives → toring=0xB455 and tx_ready stays 1.
- Same-cycle consume+insert: TX holds 0x055→3 and fromring=0xAAAB → toring=0xB455, and the RX FIFO gains {5,0x0AB}.
- RX full (DEPTH=4): with rx_ready=0, send five 0xAAAB words → the fifth is forwarded unchanged; after one pop, the next 0xAAAB is consumed.
- Orphan with macro defined, ADDRESS=2: fromring=0xB455-like word with src=2, dest=3 → slot emptied and orphan=1. Without the macro → forwarded and orphan=0.
